// File: rtl/sprite_cmd_dispatcher.sv
// sprite_cmd_dispatcher: Avalon-MM command FIFO driving the sprite command bus with vblank-gated buffer swaps.
// Define DISP_AUTO_BUFSEL_EN to force bit 13 of every popped command to the back buffer (~front_buf).
module sprite_cmd_dispatcher #(
  parameter int FIFO_DEPTH = 16,
  parameter int V_ACTIVE   = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        front_buf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, WAIT_VBL} state_t;
  state_t state_q, state_d;
  logic [32:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] level_q, level_d, markers_q, markers_d;
  logic overflow_q, overflow_d, bad_cmd_q, bad_cmd_d, front_q, front_d, swapped_q, swapped_d;
  logic [31:0] readdata_q, readdata_d, head_word, cmd_word;
  logic wr_en, clr, push, push_ok, pop, full, empty, in_vblank, head_marker, swap_go, unused_ok;
  assign wr_en       = chipselect & write;
  assign clr         = wr_en & address == 2'd2 & writedata[0];
  assign in_vblank   = 32'(vcount) >= V_ACTIVE;
  assign head_marker = mem_q[rd_ptr_q][32];
  assign head_word   = mem_q[rd_ptr_q][31:0];
  assign empty       = level_q == '0;
  assign full        = level_q == (AW+1)'(FIFO_DEPTH);
  assign push        = wr_en & ((address == 2'd0 & writedata[20:17] != 4'hf) | address == 2'd1);
  assign push_ok     = push & ~full;
  assign swap_go     = state_q == WAIT_VBL & in_vblank & ~swapped_q;
  assign pop         = (state_q == RUN & ~empty & ~head_marker) | swap_go;
  assign unused_ok   = ^hcount;
  assign readdata    = readdata_q;
  assign front_buf   = front_q;
`ifdef DISP_AUTO_BUFSEL_EN
  assign cmd_word = {head_word[31:14], ~front_q, head_word[12:0]};
`else
  assign cmd_word = head_word;
`endif
  always_comb begin
    state_d = state_q;
    cmd_out = '0;
    case (state_q)
      IDLE: state_d = empty ? IDLE : RUN;
      RUN: begin
        state_d = empty ? IDLE : head_marker ? WAIT_VBL : RUN;
        cmd_out = (empty | head_marker) ? '0 : cmd_word;
      end
      WAIT_VBL: begin
        state_d = swap_go ? RUN : WAIT_VBL;
        cmd_out = swap_go ? {11'b0, 4'hf, 3'b0, ~front_q, 13'b0} : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    level_d    = level_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    markers_d  = markers_q + (AW+1)'(push_ok & address == 2'd1) - (AW+1)'(swap_go);
    front_d    = front_q ^ swap_go;
    swapped_d  = in_vblank & (swapped_q | swap_go);
    overflow_d = clr ? 1'b0 : overflow_q | (push & full);
    bad_cmd_d  = clr ? 1'b0 : bad_cmd_q | (wr_en & address == 2'd0 & writedata[20:17] == 4'hf);
    readdata_d = ~(chipselect & read) ? readdata_q :
                 address != 2'd0 ? '0 :
                 {12'b0, bad_cmd_q, markers_q != '0, front_q, overflow_q, 8'b0, 8'(level_q)};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      markers_q  <= '0;
      overflow_q <= 1'b0;
      bad_cmd_q  <= 1'b0;
      front_q    <= 1'b0;
      swapped_q  <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q   <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_q    <= level_d;
      markers_q  <= markers_d;
      overflow_q <= overflow_d;
      bad_cmd_q  <= bad_cmd_d;
      front_q    <= front_d;
      swapped_q  <= swapped_d;
      readdata_q <= readdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {address == 2'd1, writedata};
  end
endmodule

// File: tb/tb_sprite_cmd_dispatcher.sv
// tb_sprite_cmd_dispatcher: directed and random stimulus checked against a queue-based model of the dispatcher.
module tb_sprite_cmd_dispatcher;
  localparam int DEPTH = 16;
`ifdef DISP_AUTO_BUFSEL_EN
  localparam logic [31:0] T1 = 32'h3C22_6005, T6 = 32'h0000_0001;
`else
  localparam logic [31:0] T1 = 32'h3C22_4005, T6 = 32'h0000_2001;
`endif
  logic clk = 0, reset = 1, chipselect = 0, write = 0, read = 0;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0, readdata, cmd_out;
  logic [9:0] hcount = 0, vcount = 0;
  logic front_buf;
  int checks = 0, errors = 0;
  bit started = 0;
  sprite_cmd_dispatcher #(.FIFO_DEPTH(DEPTH), .V_ACTIVE(480)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .hcount(hcount),
    .vcount(vcount), .cmd_out(cmd_out), .front_buf(front_buf)
  );
  always #5 clk = ~clk;
  // Model: q holds queued entries; mode 0 = dispatcher noticing the queue, 1 = issuing, 2 = holding for vblank.
  logic [32:0] q[$];
  int mode = 0;
  bit m_fb = 0, m_ovf = 0, m_bad = 0, m_sw = 0;
  logic [31:0] m_rd = 0;
  function automatic logic [31:0] emitted(logic [31:0] w);
`ifdef DISP_AUTO_BUFSEL_EN
    w[13] = ~m_fb;
`endif
    return w;
  endfunction
  function automatic bit has_marker();
    foreach (q[i]) if (q[i][32]) return 1;
    return 0;
  endfunction
  function automatic logic [31:0] status();
    return {12'b0, m_bad, has_marker(), m_fb, m_ovf, 8'b0, 8'(q.size())};
  endfunction
  function automatic logic [31:0] exp_cmd();
    if (mode == 1 && q.size() > 0 && !q[0][32]) return emitted(q[0][31:0]);
    if (mode == 2 && vcount >= 480 && !m_sw) return 32'h001E_0000 | (m_fb ? 32'h0 : 32'h2000);
    return 32'h0;
  endfunction
  always @(posedge clk) begin
    bit vbl, full, pop, swap;
    if (reset) begin
      q.delete();
      mode = 0;
      m_fb = 0; m_ovf = 0; m_bad = 0; m_sw = 0; m_rd = 0;
    end else begin
      vbl = vcount >= 480;
      full = q.size() == DEPTH;
      pop = 0;
      swap = 0;
      if (chipselect && read) m_rd = address == 0 ? status() : 32'h0;
      if (mode == 0) mode = q.size() > 0 ? 1 : 0;
      else if (mode == 1) begin
        if (q.size() == 0) mode = 0;
        else if (q[0][32]) mode = 2;
        else pop = 1;
      end else if (vbl && !m_sw) begin
        pop = 1; swap = 1; mode = 1;
      end
      if (chipselect && write) begin
        if (address == 0 && writedata[20:17] == 4'hf) m_bad = 1;
        else if (address <= 1) begin
          if (full) m_ovf = 1;
          else q.push_back({address == 1, writedata});
        end else if (address == 2 && writedata[0]) begin
          m_ovf = 0; m_bad = 0;
        end
      end
      if (pop) void'(q.pop_front());
      if (swap) m_fb = ~m_fb;
      m_sw = vbl && (m_sw || swap);
    end
  end
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) if (started) begin
    chk("cmd_out", cmd_out, exp_cmd());
    chk("front_buf", 32'(front_buf), 32'(m_fb));
    chk("readdata", readdata, m_rd);
  end
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(logic [1:0] a, logic [31:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    step(1);
    chipselect = 0; write = 0;
  endtask
  task automatic rd(logic [1:0] a, output logic [31:0] v);
    chipselect = 1; read = 1; address = a;
    step(1);
    chipselect = 0; read = 0;
    v = readdata;
  endtask
  initial begin
    logic [31:0] v;
    int r;
    step(2);
    reset = 0;
    started = 1;
    chk("reset_cmd", cmd_out, 0);
    chk("reset_fb", 32'(front_buf), 0);
    rd(0, v);
    chk("reset_status", v, 0);
    wr(0, 32'h3C22_4005);
    step(1);
    chk("t1_cmd", cmd_out, T1);
    step(1);
    chk("t1_idle", cmd_out, 0);
    rd(0, v);
    chk("t1_level", v[7:0], 0);
    vcount = 100;
    wr(0, 32'h0000_0011); wr(0, 32'h0000_0022); wr(0, 32'h0000_0033); wr(1, 0); wr(0, 32'h0102_0304);
    step(12);
    chk("t2_hold", cmd_out, 0);
    vcount = 480;
    #1;
    chk("t2_swap", cmd_out, 32'h001E_2000);
    step(1);
    chk("t2_fb1", 32'(front_buf), 1);
    chk("t2_last", cmd_out, 32'h0102_0304);
    reset = 1;
    step(2);
    reset = 0;
    wr(1, 0); wr(1, 0);
    step(6);
    chk("t3_first", 32'(front_buf), 1);
    step(10);
    chk("t3_hold", 32'(front_buf), 1);
    vcount = 100;
    step(3);
    vcount = 480;
    step(4);
    chk("t3_second", 32'(front_buf), 0);
    vcount = 100;
    wr(1, 0);
    for (int i = 0; i < 17; i++) wr(0, 32'h100 + i);
    rd(0, v);
    chk("t4_level", v[7:0], 16);
    chk("t4_ovf", v[16], 1);
    chk("t4_marker", v[18], 1);
    wr(2, 1);
    rd(0, v);
    chk("t4_clear", v[16], 0);
    vcount = 480;
    step(30);
    wr(0, 32'h001E_0000);
    step(2);
    rd(0, v);
    chk("t5_bad", v[19], 1);
    chk("t5_level", v[7:0], 0);
    chk("t5_fb", 32'(front_buf), 1);
    wr(2, 1);
    wr(0, 32'h0000_2001);
    step(1);
    chk("t6_bit13", cmd_out, T6);
    vcount = 100;
    step(2);
    wr(1, 0);
    step(4);
    reset = 1;
    vcount = 480;
    step(2);
    reset = 0;
    step(10);
    chk("t6_no_swap", cmd_out, 0);
    rd(0, v);
    chk("t6_level", v[7:0], 0);
    for (int c = 0; c < 4000; c++) begin
      vcount = 10'(c % 60 < 50 ? (c % 60) * 9 : 480 + (c % 60 - 50) * 3);
      hcount = 10'($urandom);
      r = $urandom_range(0, 99);
      if (c == 3000) begin
        reset = 1;
        step(1);
        reset = 0;
      end else if (r < 45) wr(0, $urandom);
      else if (r < (c < 2000 ? 47 : 55)) wr(1, $urandom);
      else if (r < 58) wr(2, $urandom);
      else if (r < 60) wr(3, $urandom);
      else if (r < 72) rd(2'($urandom), v);
      else step(1);
    end
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
